// File: rtl/shader_pkg.sv
// Shared constants and state encoding for the tiny shader pipeline.
// Imported by the scheduler, execute unit and timing generator.
package shader_pkg;

    localparam int NUM_INSTR = 16;
    localparam int ADDR_W    = $clog2(NUM_INSTR);
    localparam int INSTR_W   = 8;
    localparam int MIN_SLOT  = NUM_INSTR + 3;

    localparam logic [ADDR_W-1:0] LAST_PC = ADDR_W'(NUM_INSTR - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        LATCH
    } sched_state_t;

endpackage

// File: rtl/shader_scheduler.sv
// Per-pixel program sequencer; owns the shader-memory port during a run
// and grants loader writes only while idle.
import shader_pkg::*;

module shader_scheduler (
    input  logic               clk,
    input  logic               reset,
    input  logic               slot_start,
    input  logic               halt,
    input  logic               wr_req,
    input  logic [ADDR_W-1:0]  wr_addr,
    input  logic [INSTR_W-1:0] wr_data,
    output logic               wr_ack,
    output logic [ADDR_W-1:0]  mem_addr,
    output logic               mem_we,
    output logic [INSTR_W-1:0] mem_wdata,
    output logic               exec_valid,
    output logic               exec_first,
    output logic               color_latch,
    output logic               busy,
    output logic               overrun
);

    sched_state_t      state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic              exec_valid_q, exec_valid_d;
    logic              exec_first_q, exec_first_d;
    logic              color_latch_q, color_latch_d;
    logic              busy_q, busy_d;
    logic              overrun_q, overrun_d;

    logic idle;
    logic start_run;
    logic grant;

    assign idle      = (state_q == IDLE);
    assign start_run = idle && slot_start && !halt;
    // A starting run takes the port; the loader retries next idle cycle.
    assign grant     = idle && wr_req && !start_run && !reset;

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        exec_valid_d  = (state_q == RUN);
        exec_first_d  = (state_q == RUN) && (pc_q == '0);
        color_latch_d = (state_q == DRAIN);
        overrun_d     = overrun_q | (slot_start && !idle);
        case (state_q)
            IDLE: begin
                if (start_run) begin
                    state_d = RUN;
                    pc_d    = '0;
                end
            end
            RUN: begin
                pc_d = pc_q + 1'b1;
                if (pc_q == LAST_PC) begin
                    state_d = DRAIN;
                end
            end
            DRAIN:   state_d = LATCH;
            LATCH:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            pc_q          <= '0;
            exec_valid_q  <= 1'b0;
            exec_first_q  <= 1'b0;
            color_latch_q <= 1'b0;
            busy_q        <= 1'b0;
            overrun_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            exec_valid_q  <= exec_valid_d;
            exec_first_q  <= exec_first_d;
            color_latch_q <= color_latch_d;
            busy_q        <= busy_d;
            overrun_q     <= overrun_d;
        end
    end

    always_comb begin
        mem_we    = grant;
        wr_ack    = grant;
        mem_wdata = grant ? wr_data : '0;
        if (grant) begin
            mem_addr = wr_addr;
        end else if (state_q == RUN) begin
            mem_addr = pc_q;
        end else begin
            mem_addr = '0;
        end
    end

    assign exec_valid  = exec_valid_q;
    assign exec_first  = exec_first_q;
    assign color_latch = color_latch_q;
    assign busy        = busy_q;
    assign overrun     = overrun_q;

endmodule
